// File: rtl/enc_unbinder_seq.sv
`default_nettype none
// ============================================================================
// Module      : enc_unbinder_seq
// Description : Captures a packet of shift-bound hypervectors and replays each
//               one circularly rotated back by its feature's shift, one beat
//               per valid/ready handshake. Optional macro UNBIND_OVERLAP_EN
//               adds a per-beat popcount of (recovered vector & ref_hv).
// Revision    : 1.0 - initial release
// ============================================================================
module enc_unbinder_seq #(
    parameter int HV_DIM          = 1024,
    parameter int FEATURES_PER_CC = 8,
    parameter int SHIFT_BASE      = 0,
    parameter int SHIFT_STEP      = 1,
    localparam int c_idx_w        = (FEATURES_PER_CC > 1) ? $clog2(FEATURES_PER_CC) : 1,
    localparam int c_cnt_w        = $clog2(HV_DIM + 1)
) (
    input  logic                                    clk,
    input  logic                                    nrst,
    input  logic                                    start_decoding,
    input  logic                                    en,
    input  logic [FEATURES_PER_CC-1:0][HV_DIM-1:0]  shifted_hv,
`ifdef UNBIND_OVERLAP_EN
    input  logic [HV_DIM-1:0]                       ref_hv,
    output logic [c_cnt_w-1:0]                      overlap_cnt,
`endif
    output logic                                    busy,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [HV_DIM-1:0]                       out_hv,
    output logic [c_idx_w-1:0]                      out_idx,
    output logic                                    out_last,
    output logic                                    done
);

    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(FEATURES_PER_CC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t                                 r_state;
    logic [FEATURES_PER_CC-1:0][HV_DIM-1:0] r_buf;
    logic [c_idx_w-1:0]                     r_idx;

    logic [FEATURES_PER_CC-1:0][HV_DIM-1:0] w_unrot;
    logic [c_idx_w-1:0]                     w_sel_idx;
    logic [HV_DIM-1:0]                      w_sel_hv;
    logic                                   w_sel_last;

    // Each feature's shift is an elaboration constant, so the inverse rotation
    // is pure wiring: out[k] = in[(k + S) mod HV_DIM].
    for (genvar g = 0; g < FEATURES_PER_CC; g++) begin : g_unrot
        localparam int c_shift = (((SHIFT_BASE + g * SHIFT_STEP) % HV_DIM) + HV_DIM) % HV_DIM;
        if (c_shift == 0) begin : g_ident
            assign w_unrot[g] = r_buf[g];
        end else begin : g_rot
            assign w_unrot[g] = {r_buf[g][c_shift-1:0], r_buf[g][HV_DIM-1:c_shift]};
        end
    end

    // In EMIT the mux looks one index ahead so the next beat is ready on accept.
    always_comb begin
        w_sel_idx = r_idx;
        if (r_state == S_EMIT) begin
            w_sel_idx = r_idx + 1'b1;
        end
        w_sel_hv = '0;
        for (int i = 0; i < FEATURES_PER_CC; i++) begin
            if (w_sel_idx == c_idx_w'(i)) begin
                w_sel_hv = w_unrot[i];
            end
        end
        w_sel_last = (w_sel_idx == c_last_idx);
    end

`ifdef UNBIND_OVERLAP_EN
    function automatic logic [c_cnt_w-1:0] popcount(input logic [HV_DIM-1:0] v);
        logic [c_cnt_w-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < HV_DIM; i++) begin
            cnt = cnt + c_cnt_w'(v[i]);
        end
        return cnt;
    endfunction

    logic [c_cnt_w-1:0] w_overlap;
    assign w_overlap = popcount(w_sel_hv & ref_hv);
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state   <= S_IDLE;
            r_buf     <= '0;
            r_idx     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_hv    <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
`ifdef UNBIND_OVERLAP_EN
            overlap_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_decoding && en) begin
                        r_buf   <= shifted_hv;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    out_hv    <= w_sel_hv;
                    out_idx   <= w_sel_idx;
                    out_last  <= w_sel_last;
                    out_valid <= 1'b1;
`ifdef UNBIND_OVERLAP_EN
                    overlap_cnt <= w_overlap;
`endif
                    r_state   <= S_EMIT;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            r_idx     <= '0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_idx    <= w_sel_idx;
                            out_hv   <= w_sel_hv;
                            out_idx  <= w_sel_idx;
                            out_last <= w_sel_last;
`ifdef UNBIND_OVERLAP_EN
                            overlap_cnt <= w_overlap;
`endif
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_enc_unbinder_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_enc_unbinder_seq
// Description : Self-checking bench for enc_unbinder_seq; two instances with
//               different shift bases share stimulus, scoreboarded per beat.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_enc_unbinder_seq;

    localparam int HV = 16;
    localparam int F  = 4;
    localparam int IW = 2;
    localparam int CW = 5;
    localparam logic [HV-1:0] c_ref = 16'h00FF;

    typedef struct packed {
        logic [HV-1:0] hv;
        logic [IW-1:0] idx;
        logic          last;
        logic [CW-1:0] ov;
    } exp_t;

    typedef struct {
        logic [F-1:0][HV-1:0] data;
        logic                 en;
    } vec_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic start_decoding = 1'b0;
    logic en = 1'b0;
    logic out_ready = 1'b0;
    logic [F-1:0][HV-1:0] shifted_hv = '0;

    logic busy_a, valid_a, last_a, done_a;
    logic busy_b, valid_b, last_b, done_b;
    logic [HV-1:0] hv_a, hv_b;
    logic [IW-1:0] idx_a, idx_b;
    logic [CW-1:0] ov_a, ov_b;

    int n_vec = 0;
    int n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic pend_a = 1'b0;
    logic pend_b = 1'b0;

    always #5 clk = ~clk;

`ifdef UNBIND_OVERLAP_EN
    logic [HV-1:0] ref_hv = c_ref;
`else
    assign ov_a = '0;
    assign ov_b = '0;
`endif

    enc_unbinder_seq #(.HV_DIM(HV), .FEATURES_PER_CC(F), .SHIFT_BASE(1), .SHIFT_STEP(1)) dut_a (
        .clk(clk), .nrst(nrst), .start_decoding(start_decoding), .en(en),
        .shifted_hv(shifted_hv),
`ifdef UNBIND_OVERLAP_EN
        .ref_hv(ref_hv), .overlap_cnt(ov_a),
`endif
        .busy(busy_a), .out_valid(valid_a), .out_ready(out_ready), .out_hv(hv_a),
        .out_idx(idx_a), .out_last(last_a), .done(done_a)
    );

    enc_unbinder_seq #(.HV_DIM(HV), .FEATURES_PER_CC(F), .SHIFT_BASE(15), .SHIFT_STEP(1)) dut_b (
        .clk(clk), .nrst(nrst), .start_decoding(start_decoding), .en(en),
        .shifted_hv(shifted_hv),
`ifdef UNBIND_OVERLAP_EN
        .ref_hv(ref_hv), .overlap_cnt(ov_b),
`endif
        .busy(busy_b), .out_valid(valid_b), .out_ready(out_ready), .out_hv(hv_b),
        .out_idx(idx_b), .out_last(last_b), .done(done_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [HV-1:0] unrot(input logic [HV-1:0] v, input int s);
        logic [HV-1:0] r;
        for (int k = 0; k < HV; k++) r[k] = v[(k + s) % HV];
        return r;
    endfunction

    function automatic logic [CW-1:0] popc(input logic [HV-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int k = 0; k < HV; k++) c = c + CW'(v[k]);
        return c;
    endfunction

    task automatic push_pkt(input logic [F-1:0][HV-1:0] d);
        exp_t e;
        for (int i = 0; i < F; i++) begin
            e.idx  = IW'(i);
            e.last = (i == F - 1);
            e.hv   = unrot(d[i], (1 + i) % HV);
            e.ov   = popc(e.hv & c_ref);
            qa.push_back(e);
            e.hv   = unrot(d[i], (15 + i) % HV);
            e.ov   = popc(e.hv & c_ref);
            qb.push_back(e);
        end
    endtask

    // Compare one instance's visible beat against the head of its queue.
    task automatic mon(input int d, input logic v, input logic l, input logic [HV-1:0] hv,
                       input logic [IW-1:0] idx, input logic dn, input logic [CW-1:0] ov);
        exp_t e;
        logic pend;
        int   qs;
        pend = (d == 0) ? pend_a : pend_b;
        if (pend) check($sformatf("done_%0d", d), 32'(dn), 32'd1);
        else if (dn) check($sformatf("spurious_done_%0d", d), 32'(dn), 32'd0);
        pend = 1'b0;
        if (v) begin
            qs = (d == 0) ? qa.size() : qb.size();
            if (qs == 0) begin
                check($sformatf("unexpected_valid_%0d", d), 32'(v), 32'd0);
            end else begin
                e = (d == 0) ? qa[0] : qb[0];
                check($sformatf("out_hv_%0d", d), 32'(hv), 32'(e.hv));
                check($sformatf("out_idx_%0d", d), 32'(idx), 32'(e.idx));
                check($sformatf("out_last_%0d", d), 32'(l), 32'(e.last));
`ifdef UNBIND_OVERLAP_EN
                check($sformatf("overlap_cnt_%0d", d), 32'(ov), 32'(e.ov));
`endif
                if (out_ready) begin
                    if (d == 0) void'(qa.pop_front());
                    else void'(qb.pop_front());
                    pend = e.last;
                end
            end
        end
        if (d == 0) pend_a = pend;
        else pend_b = pend;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (nrst) begin
                mon(0, valid_a, last_a, hv_a, idx_a, done_a, ov_a);
                mon(1, valid_b, last_b, hv_b, idx_b, done_b, ov_b);
            end else begin
                pend_a = 1'b0;
                pend_b = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [F-1:0][HV-1:0] d, input logic e_in, input logic expect_cap);
        if (expect_cap) push_pkt(d);
        shifted_hv     = d;
        en             = e_in;
        start_decoding = 1'b1;
        tick();
        start_decoding = 1'b0;
        en             = 1'b0;
        shifted_hv     = ~d;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100 && (busy_a || busy_b); c++) tick();
        check("idle_timeout", 32'(busy_a | busy_b), 32'd0);
        tick();
        check("queue_drained", 32'(qa.size() + qb.size()), 32'd0);
    endtask

    task automatic wait_cond_valid_idx(input logic [IW-1:0] want);
        int c;
        for (c = 0; c < 50 && !(valid_a && idx_a == want); c++) tick();
        check("wait_beat_timeout", 32'(c < 50), 32'd1);
    endtask

    vec_t vecs [4];
    logic [F-1:0][HV-1:0] pkt_a;
    logic [F-1:0][HV-1:0] pkt_b;

    initial begin
        vecs[0].data = {16'h0010, 16'h0008, 16'h0004, 16'h0002};
        vecs[0].en   = 1'b1;
        vecs[1].data = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        vecs[1].en   = 1'b0;
        vecs[2].data = {16'h8001, 16'h1234, 16'hA5C3, 16'h0001};
        vecs[2].en   = 1'b1;
        vecs[3].data = {16'hF00F, 16'hBEEF, 16'hDEAD, 16'h1E1E};
        vecs[3].en   = 1'b1;
        pkt_a = {16'hCAFE, 16'h0F0F, 16'h7001, 16'h8000};
        pkt_b = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

        // Reset state
        tick();
        tick();
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_hv", 32'(hv_a), 32'd0);
        check("rst_idx", 32'(idx_a), 32'd0);
        check("rst_last", 32'(last_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        nrst = 1'b1;
        out_ready = 1'b1;
        tick();

        // Table-driven packets with full-rate acceptance
        for (int v = 0; v < 4; v++) begin
            do_start(vecs[v].data, vecs[v].en, vecs[v].en);
            if (vecs[v].en) begin
                check("busy_after_capture", 32'(busy_a), 32'd1);
                check("latency_cycle1_valid", 32'(valid_a), 32'd0);
                tick();
                check("latency_cycle2_valid", 32'(valid_a), 32'd1);
                wait_idle();
            end else begin
                repeat (3) tick();
                check("gated_busy", 32'(busy_a), 32'd0);
                check("gated_valid", 32'(valid_a), 32'd0);
            end
        end

        // Backpressure at idx 2 for three cycles
        do_start(pkt_a, 1'b1, 1'b1);
        wait_cond_valid_idx(2'd2);
        out_ready = 1'b0;
        repeat (3) tick();
        check("bp_idx_held", 32'(idx_a), 32'd2);
        check("bp_valid_held", 32'(valid_a), 32'd1);
        out_ready = 1'b1;
        wait_idle();

        // Start while busy is ignored
        out_ready = 1'b0;
        do_start(pkt_a, 1'b1, 1'b1);
        repeat (3) tick();
        do_start(pkt_b, 1'b1, 1'b0);
        repeat (2) tick();
        check("busy_during_ignored_start", 32'(busy_a), 32'd1);
        out_ready = 1'b1;
        wait_idle();

        // Reset after idx 1 is accepted
        out_ready = 1'b0;
        do_start(vecs[3].data, 1'b1, 1'b1);
        wait_cond_valid_idx(2'd0);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_valid", 32'(valid_a), 32'd0);
        check("midrst_hv", 32'(hv_a), 32'd0);
        check("midrst_idx", 32'(idx_a), 32'd0);
        check("midrst_last", 32'(last_a), 32'd0);
        check("midrst_done", 32'(done_a), 32'd0);
        qa.delete();
        qb.delete();
        repeat (3) tick();
        out_ready = 1'b1;
        do_start(vecs[2].data, 1'b1, 1'b1);
        wait_idle();

        // New start taken in the same cycle done is high
        do_start(vecs[0].data, 1'b1, 1'b1);
        for (int c = 0; c < 50 && !done_a; c++) tick();
        check("done_seen", 32'(done_a), 32'd1);
        do_start(pkt_a, 1'b1, 1'b1);
        check("start_on_done_busy", 32'(busy_a), 32'd1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/enc_unbinder_seq.md
Name: enc_unbinder_seq

Overview:
- Inverse of the per-feature shift binder stage in the sparse HDC encoder.
- Captures one packet of FEATURES_PER_CC bound (shifted) hypervectors on start. Then emits the recovered level hypervectors one per accepted beat, each circularly rotated back by its feature's shift.
- Used on the decode/verification path, and for query inspection behind the encoder pack.

Parameters:
- HV_DIM, 1024, hypervector width in bits.
- FEATURES_PER_CC, 8, vectors per packet; must be ≥ 1.
- SHIFT_BASE, 0, shift amount of feature 0.
- SHIFT_STEP, 1, shift increment per feature.
  - Shift of feature i = (SHIFT_BASE + i*SHIFT_STEP) mod HV_DIM, evaluated at elaboration.

Ports:
- clk  in  1  clock.
- nrst  in  1  synchronous active-low reset.
- start_decoding  in  1  capture request pulse.
- en  in  1  gates start_decoding; capture only when start_decoding && en.
- shifted_hv  in  [HV_DIM-1:0] x FEATURES_PER_CC  bound vectors, sampled on capture.
- busy  out  1  high from capture until the last beat is accepted.
- out_valid  out  1  out_hv/out_idx valid.
- out_ready  in  1  downstream accept.
- out_hv  out  HV_DIM  recovered level hypervector.
- out_idx  out  clog2(FEATURES_PER_CC) (min 1)  feature index of out_hv.
- out_last  out  1  high with the final feature's beat.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset: all outputs and registers clear on a clk edge with nrst=0.
  - busy=0, out_valid=0, out_hv=0, out_idx=0, out_last=0, done=0.
  - Capture buffer cleared; FSM=IDLE.
  - Reset mid-packet discards the packet; no done pulse.
- Rotation convention:
  - The encoder moves bit k to (k+S) mod HV_DIM.
  - The unbinder outputs out_hv[k] = shifted_hv[i][(k+S_i) mod HV_DIM].
  - S_i=0 is identity.
- FSM states:
  - IDLE: on start_decoding && en, latch all FEATURES_PER_CC vectors into the buffer, set busy=1, idx=0, go LOAD. Otherwise hold.
  - LOAD: register out_hv = unrotate(buf[idx], S_idx); set out_valid=1, out_idx=idx, out_last=(idx==FEATURES_PER_CC-1); go EMIT.
    - Capture-to-first-valid latency is 2 cycles.
  - EMIT: hold out_hv/out_idx/out_last stable while out_valid && !out_ready.
    - On accept with !out_last: idx++, present the next beat in the next cycle with out_valid kept high. Pipelined: back-to-back beats when out_ready is held high.
    - On accept with out_last: out_valid=0, busy=0, done=1 for one cycle, go IDLE.
- start_decoding while busy: ignored; buffer not overwritten.
- A start in the same cycle as done: accepted, because the FSM is already IDLE in that cycle only if done was already asserted. Precisely, a start is taken on the cycle done=1, since the state is IDLE.
- FEATURES_PER_CC=1: a single beat with out_last=1.
- Rotation is a mux per feature index; the index counter wraps to 0 at end of packet.

Optional Feature:
- Macro: UNBIND_OVERLAP_EN.
- Defined:
  - Adds input ref_hv [HV_DIM-1:0] and output overlap_cnt [clog2(HV_DIM+1)-1:0].
  - overlap_cnt = popcount(unrotated vector & ref_hv), registered and valid with the same beat as out_hv.
  - Resets to 0; held under backpressure.
  - ref_hv is sampled in the LOAD/advance cycle.
- Undefined: ports absent, no popcount logic; all other behaviour identical.

Test Plan:
- Basic unrotate:
  - Stimulus: HV_DIM=16, FEATURES_PER_CC=4, SHIFT_BASE=1, SHIFT_STEP=1; shifted_hv[i]=16'h0001<<(i+1); start with en=1; out_ready=1.
  - Response: out_hv=16'h0001 for idx 0..3; first out_valid 2 cycles after start; 4 consecutive beats; out_last on idx 3; done one cycle after.
- Wrap-around:
  - Stimulus: SHIFT_BASE=15, STEP=1, HV_DIM=16; feature 1 shift=0, feature 0 input 16'h0001.
  - Response: idx0 out_hv=16'h0002; idx1 output equals its input.
- Backpressure:
  - Stimulus: drop out_ready for 3 cycles at idx 2.
  - Response: out_hv/out_idx/out_last stable, out_valid high, no skipped or duplicated index.
- Gating and busy:
  - Stimulus: start with en=0; later a start during busy with different data.
  - Response: no capture; the second packet is ignored and outputs match the first packet.
- Reset mid-packet:
  - Stimulus: nrst=0 for 1 cycle after idx 1 is accepted.
  - Response: all outputs 0 on the next edge, no done; a new start runs a full packet from idx 0.
- Overlap (UNBIND_OVERLAP_EN):
  - Stimulus: ref_hv=16'h00FF; unrotated vector 16'h0F0F.
  - Response: overlap_cnt=4 on that beat.
